// File: rtl/vigna_prefetch_if.sv
// Instruction-bus bundle between the vigna prefetch queue (master) and the
// instruction memory / bus slave.
interface vigna_prefetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_valid;
    logic                  i_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [31:0]           i_rdata;

    modport master (
        output i_valid,
        output i_addr,
        input  i_ready,
        input  i_rdata
    );

    modport slave (
        input  i_valid,
        input  i_addr,
        output i_ready,
        output i_rdata
    );
endinterface

// File: rtl/vigna_prefetch.sv
// DEPTH-entry instruction prefetch queue for the vigna core family.
// Optional same-cycle bus-to-decode bypass: define VIGNA_PREFETCH_BYPASS_EN.
//
// state  | meaning
// IDLE   | no request outstanding, waiting for queue room
// REQ    | request at fetch_pc outstanding on the bus
// DROP   | stale request outstanding after a redirect; response discarded
module vigna_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    localparam int                   PW         = $clog2(DEPTH),
    localparam int                   CW         = PW + 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    vigna_prefetch_if.master       bus,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [31:0]            out_inst,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [CW-1:0]          out_count
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    localparam logic [ADDR_WIDTH-1:0] MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                r_state;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_pc_q   [DEPTH];
    logic [31:0]           r_inst_q [DEPTH];

    logic                  w_accept;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_byp_take;
    logic                  w_room;
    logic [CW-1:0]         w_count_next;
    logic [ADDR_WIDTH-1:0] w_redir_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign bus.i_valid = r_valid;
    assign bus.i_addr  = r_addr;
    assign out_count   = r_count;

    assign w_accept   = r_valid && bus.i_ready;
    assign w_empty    = (r_count == '0);
    assign w_redir_pc = redirect_pc & MASK;
    assign w_next_pc  = redirect_valid ? w_redir_pc : r_fetch_pc;
    assign w_pc_inc   = r_fetch_pc + ADDR_WIDTH'(4);

`ifdef VIGNA_PREFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass   = (r_state == S_REQ) && w_empty && bus.i_ready && !redirect_valid;
    assign w_byp_take = w_bypass && out_ready;

    always_comb begin
        out_valid = !w_empty || w_bypass;
        out_pc    = w_empty ? r_fetch_pc  : r_pc_q[r_rd_ptr];
        out_inst  = w_empty ? bus.i_rdata : r_inst_q[r_rd_ptr];
    end
`else
    assign w_byp_take = 1'b0;

    always_comb begin
        out_valid = !w_empty;
        out_pc    = r_pc_q[r_rd_ptr];
        out_inst  = r_inst_q[r_rd_ptr];
    end
`endif

    assign w_pop  = !w_empty && out_ready && !redirect_valid;
    assign w_push = w_accept && (r_state == S_REQ) && !redirect_valid && !w_byp_take;

    assign w_count_next = redirect_valid ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_room       = (w_count_next < CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr]   <= r_addr;
            r_inst_q[r_wr_ptr] <= bus.i_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_addr     <= RESET_ADDR & MASK;
            r_fetch_pc <= RESET_ADDR & MASK;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_count <= w_count_next;
            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_fetch_pc <= w_next_pc;
                    if (w_room) begin
                        r_valid <= 1'b1;
                        r_addr  <= w_next_pc;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                        // Response in this cycle is discarded; the flushed queue always has room.
                        if (bus.i_ready) r_addr  <= w_redir_pc;
                        else             r_state <= S_DROP;
                    end else if (bus.i_ready) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_room) begin
                            r_addr <= w_pc_inc;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    r_fetch_pc <= w_next_pc;
                    if (bus.i_ready) begin
                        if (w_room) begin
                            r_addr  <= w_next_pc;
                            r_state <= S_REQ;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vigna_prefetch.sv
// Scoreboard bench for vigna_prefetch: directed scenarios plus a random phase,
// with a protocol/queue model checking every cycle on the falling edge.
module tb_vigna_prefetch;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk;
    logic        resetn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  out_count;

    int checks = 0;
    int errors = 0;

    entry_t      sb[$];
    bit          stale;
    logic [31:0] exp_fetch;
    bit          prev_valid;
    bit          prev_accept;
    logic [31:0] prev_addr;

    vigna_prefetch_if #(.ADDR_WIDTH(32)) bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.i_rdata = mem_word(bus.i_addr);

    vigna_prefetch #(
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_ADDR (32'h0)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_count      (out_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_to(input string tag, input logic [31:0] a);
        bit found = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.i_valid && bus.i_addr == a) begin
                found = 1;
                break;
            end
            tick(1);
        end
        check(tag, found, 1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    // Cycle model: checks outputs against the scoreboard, then applies the coming edge.
    always @(negedge clk) begin
        int  n;
        bit  accept;
        bit  byp;
        if (!resetn) begin
            sb.delete();
            stale       = 0;
            exp_fetch   = 32'h0;
            prev_valid  = 0;
            prev_accept = 0;
            prev_addr   = 32'h0;
        end else begin
            n      = sb.size();
            accept = bus.i_valid && bus.i_ready;
            byp    = 0;
`ifdef VIGNA_PREFETCH_BYPASS_EN
            byp = (n == 0) && accept && !stale && !redirect_valid;
`endif
            check("count", out_count, n);
            if (n > 0) begin
                check("head_valid", out_valid, 1);
                check("head_pc", out_pc, sb[0].pc);
                check("head_inst", out_inst, sb[0].inst);
            end else if (byp) begin
                check("byp_valid", out_valid, 1);
                check("byp_pc", out_pc, bus.i_addr);
                check("byp_inst", out_inst, mem_word(bus.i_addr));
            end else begin
                check("empty_valid", out_valid, 0);
            end

            if (bus.i_valid) begin
                if (prev_valid && !prev_accept) begin
                    check("addr_hold", bus.i_addr, prev_addr);
                end else begin
                    check("addr_new", bus.i_addr, exp_fetch);
                    check("room", (n < DEPTH), 1);
                end
            end
            prev_valid  = bus.i_valid;
            prev_accept = accept;
            prev_addr   = bus.i_addr;

            if (redirect_valid) begin
                sb.delete();
                stale     = bus.i_valid && !bus.i_ready;
                exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (out_ready && n > 0) void'(sb.pop_front());
                if (accept) begin
                    if (stale) begin
                        stale = 0;
                    end else begin
                        if (!(byp && out_ready))
                            sb.push_back('{pc: bus.i_addr, inst: mem_word(bus.i_addr)});
                        exp_fetch = bus.i_addr + 32'd4;
                    end
                end
            end
        end
    end

    initial begin
        resetn         = 1'b0;
        bus.i_ready    = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick(3);
        check("rst_ivalid", bus.i_valid, 0);
        check("rst_iaddr", bus.i_addr, 32'h0);
        check("rst_ovalid", out_valid, 0);
        check("rst_count", out_count, 0);
        resetn = 1'b1;

        // Fill with slave always ready, consumer stalled.
        bus.i_ready = 1'b1;
        tick(8);
        check("fill_count", out_count, 4);
        check("fill_ivalid", bus.i_valid, 0);
        check("fill_pc", out_pc, 32'h0);
        check("fill_inst", out_inst, mem_word(32'h0));

        // One pop from a full queue allows exactly one new request.
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pop1_count", out_count, 3);
        check("pop1_pc", out_pc, 32'h4);
        check("pop1_ivalid", bus.i_valid, 1);
        check("pop1_iaddr", bus.i_addr, 32'h10);
        tick(1);
        check("refill_count", out_count, 4);
        check("refill_ivalid", bus.i_valid, 0);

        // Stalled slave at 0x8, redirect to 0x100 while stalled.
        bus.i_ready = 1'b0;
        redirect_to(32'h0);
        bus.i_ready = 1'b1;
        out_ready   = 1'b1;
        run_to("reach_8", 32'h8);
        bus.i_ready = 1'b0;
        tick(2);
        redirect_to(32'h100);
        check("drop_hold_a", bus.i_addr, 32'h8);
        tick(2);
        check("drop_hold_b", bus.i_addr, 32'h8);
        check("drop_ivalid", bus.i_valid, 1);
        bus.i_ready = 1'b1;
        tick(1);
        check("drop_next", bus.i_addr, 32'h100);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            tick(1);
        end
        check("drop_first_pc", out_pc, 32'h100);

        // Redirect coinciding with acceptance of 0x20.
        redirect_to(32'h10);
        run_to("reach_20", 32'h20);
        out_ready = 1'b0;
        redirect_to(32'h203);
        check("same_count", out_count, 0);
        check("same_iaddr", bus.i_addr, 32'h200);
        tick(1);
`ifndef VIGNA_PREFETCH_BYPASS_EN
        check("same_head", out_pc, 32'h200);
`endif
        out_ready = 1'b1;

        // Address wrap at the top of the space.
        redirect_to(32'hFFFF_FFF8);
        run_to("reach_top", 32'hFFFF_FFFC);
        tick(1);
        check("wrap", bus.i_addr, 32'h0);

        // Fetch-to-out latency from an empty queue.
        bus.i_ready = 1'b0;
        redirect_to(32'h400);
        bus.i_ready = 1'b1;
        run_to("reach_400", 32'h400);
`ifdef VIGNA_PREFETCH_BYPASS_EN
        check("lat_valid0", out_valid, 1);
        check("lat_inst0", out_inst, mem_word(32'h400));
        tick(1);
        check("lat_count", out_count, 0);
`else
        check("lat_valid0", out_valid, 0);
        tick(1);
        check("lat_valid1", out_valid, 1);
        check("lat_pc1", out_pc, 32'h400);
`endif

        // Reset while a request is outstanding.
        bus.i_ready = 1'b0;
        tick(1);
        resetn = 1'b0;
        tick(1);
        check("mrst_ivalid", bus.i_valid, 0);
        check("mrst_count", out_count, 0);
        check("mrst_iaddr", bus.i_addr, 32'h0);
        resetn = 1'b1;
        tick(1);

        // Random traffic; the falling-edge model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            bus.i_ready    = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom();
            tick(1);
        end
        redirect_valid = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
